// File: rtl/piso_shift_tx_if.sv
// Load/serial bundle for the PISO transmitter.
// Master drives the word and baud tick; slave is the transmitter.
interface piso_shift_tx_if #(
  parameter int N = 16
);
  logic [N-1:0] D;
  logic         LOAD_VALID;
  logic         LOAD_READY;
  logic         CE;
  logic         SOUT;
  logic         SOUT_VALID;
  logic         BUSY;
  logic         DONE;

  modport master (
    output D, LOAD_VALID, CE,
    input  LOAD_READY, SOUT, SOUT_VALID, BUSY, DONE
  );

  modport slave (
    input  D, LOAD_VALID, CE,
    output LOAD_READY, SOUT, SOUT_VALID, BUSY, DONE
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, one bit per CE edge, DONE pulse.
// Optional even parity bit after the data when PISO_PARITY_EN is defined.
module piso_shift_tx #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            C,
  input  logic            CLR,
  piso_shift_tx_if.slave  bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PAR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sout_q, sout_d;
  logic          sval_q, sval_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          head_d;
`ifdef PISO_PARITY_EN
  logic          par_q, par_d;
`endif

  // Next state, shift register and bit counter
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.LOAD_VALID) begin
          sreg_d  = bus.D;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^bus.D;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.CE) begin
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end else begin
            sreg_d = MSB_FIRST ?
                     {sreg_q[N-2:0], 1'b0} :
                     {1'b0, sreg_q[N-1:1]};
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        if (bus.CE) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state
  always_comb begin
    head_d  = MSB_FIRST ? sreg_d[N-1] : sreg_d[0];
    sout_d  = 1'b0;
    sval_d  = 1'b0;
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_SHIFT: begin
        sout_d = head_d;
        sval_d = 1'b1;
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        sout_d = par_d;
        sval_d = 1'b1;
      end
`endif
      default: begin
        sout_d = 1'b0;
        sval_d = 1'b0;
      end
    endcase
  end

  // State and output registers, async clear
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.SOUT       = sout_q;
  assign bus.SOUT_VALID = sval_q;
  assign bus.DONE       = done_q;
  assign bus.LOAD_READY = ready_q;
  assign bus.BUSY       = ~ready_q;

endmodule
